// File: rtl/rob_pkg.sv
// Shared types and default sizing for the response reorder buffer.
package rob_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 4;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        PENDING = 2'b01,
        READY   = 2'b10
    } slot_state_e;

endpackage : rob_pkg

// File: rtl/rob_ptr.sv
// Wrap-bit pointer register: the extra MSB separates full from empty when low bits match.
module rob_ptr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : rob_ptr

// File: rtl/rob_reorder.sv
// Response reorder buffer: hands out ordered tags, absorbs out-of-order responses, releases in order.
// Optional ROB_BYPASS_EN: a response hitting the pending head is forwarded to the output in the same cycle.
module rob_reorder
    import rob_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int unsigned DEPTH      = DEPTH_DEF,
    localparam int unsigned ID_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [ID_WIDTH-1:0]   req_id_o,
    input  logic                  rsp_valid_i,
    input  logic [ID_WIDTH-1:0]   rsp_id_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  err_o
);

    localparam int unsigned PTR_WIDTH = ID_WIDTH + 1;

    slot_state_e           slot_q [DEPTH];
    slot_state_e           slot_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic                  err_q;
    logic                  err_d;

    logic [PTR_WIDTH-1:0]  alloc_ptr;
    logic [PTR_WIDTH-1:0]  rel_ptr;
    logic [ID_WIDTH-1:0]   alloc_idx;
    logic [ID_WIDTH-1:0]   head_idx;
    logic                  alloc_fire;
    logic                  rel_fire;
    logic                  head_ready;

    rob_ptr #(.WIDTH(PTR_WIDTH)) u_alloc_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (alloc_fire),
        .ptr_o  (alloc_ptr)
    );

    rob_ptr #(.WIDTH(PTR_WIDTH)) u_rel_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rel_fire),
        .ptr_o  (rel_ptr)
    );

    assign alloc_idx = alloc_ptr[ID_WIDTH-1:0];
    assign head_idx  = rel_ptr[ID_WIDTH-1:0];

    assign empty_o = (alloc_ptr == rel_ptr);
    assign full_o  = (alloc_ptr[ID_WIDTH] != rel_ptr[ID_WIDTH]) && (alloc_idx == head_idx);

    assign req_ready_o = ~full_o;
    assign req_id_o    = alloc_idx;
    assign alloc_fire  = req_valid_i && ~full_o;

    assign head_ready = (slot_q[head_idx] == READY);
    assign out_id_o   = head_idx;
    assign err_o      = err_q;

`ifdef ROB_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = rsp_valid_i && (rsp_id_i == head_idx) && (slot_q[head_idx] == PENDING);
    assign out_valid_o = head_ready || bypass_hit;
    assign out_data_o  = bypass_hit ? rsp_data_i : data_q[head_idx];
`else
    assign out_valid_o = head_ready;
    assign out_data_o  = data_q[head_idx];
`endif

    assign rel_fire = out_valid_o && out_ready_i;

    // Later assignments win: a bypassed release overrides the READY write, alloc lands on a FREE slot.
    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        err_d  = 1'b0;
        if (rsp_valid_i) begin
            if (slot_q[rsp_id_i] == PENDING) begin
                slot_d[rsp_id_i] = READY;
                data_d[rsp_id_i] = rsp_data_i;
            end else begin
                err_d = 1'b1;
            end
        end
        if (rel_fire) begin
            slot_d[head_idx] = FREE;
        end
        if (alloc_fire) begin
            slot_d[alloc_idx] = PENDING;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= FREE;
                data_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

endmodule : rob_reorder

// File: tb/tb_rob_reorder.sv
// Directed self-checking bench for rob_reorder (default build, DEPTH=4, DATA_WIDTH=8).
module tb_rob_reorder;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_id_o;
    logic       rsp_valid_i;
    logic [1:0] rsp_id_i;
    logic [7:0] rsp_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [1:0] out_id_o;
    logic [7:0] out_data_o;
    logic       full_o;
    logic       empty_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    rob_reorder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_id_o    (req_id_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_id_i    (rsp_id_i),
        .rsp_data_i  (rsp_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_id_o    (out_id_o),
        .out_data_o  (out_data_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and checks live 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_empty"},     32'(empty_o),     32'd1);
        check({pfx, "_full"},      32'(full_o),      32'd0);
        check({pfx, "_req_ready"}, 32'(req_ready_o), 32'd1);
        check({pfx, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({pfx, "_err"},       32'(err_o),       32'd0);
        check({pfx, "_req_id"},    32'(req_id_o),    32'd0);
        check({pfx, "_out_id"},    32'(out_id_o),    32'd0);
        check({pfx, "_out_data"},  32'(out_data_o),  32'd0);
    endtask

    initial begin
        logic [7:0] rsp_order [4];
        rsp_order[0] = 8'd3; rsp_order[1] = 8'd1; rsp_order[2] = 8'd2; rsp_order[3] = 8'd0;

        rst_ni = 1'b0; req_valid_i = 1'b0; rsp_valid_i = 1'b0;
        rsp_id_i = '0; rsp_data_i = '0; out_ready_i = 1'b0;
        #3;
        check_reset_outputs("rst");
        step();
        rst_ni = 1'b1;
        step();

        // Fill all four tags; fifth request must be refused.
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            #1;
            check("alloc_id", 32'(req_id_o), 32'(i));
            check("alloc_ready", 32'(req_ready_o), 32'd1);
            step();
        end
        check("full_after4", 32'(full_o), 32'd1);
        check("ready_when_full", 32'(req_ready_o), 32'd0);
        step();
        req_valid_i = 1'b0;
        check("still_full", 32'(full_o), 32'd1);

        // Out-of-order responses 3,1,2,0; nothing leaves until tag 0 is in.
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rsp_valid_i = 1'b1;
            rsp_id_i    = 2'(rsp_order[i]);
            rsp_data_i  = 8'hD0 + rsp_order[i];
            #1;
            check("ooo_hold_valid", 32'(out_valid_o), 32'd0);
            step();
            check("ooo_no_err", 32'(err_o), 32'd0);
        end
        rsp_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ooo_valid", 32'(out_valid_o), 32'd1);
            check("ooo_data", 32'(out_data_o), 32'(8'hD0 + 8'(k)));
            check("ooo_id", 32'(out_id_o), 32'(k));
            step();
        end
        check("ooo_empty", 32'(empty_o), 32'd1);
        check("ooo_drained", 32'(out_valid_o), 32'd0);

        // Response to a FREE slot: one-cycle error pulse, no state change.
        rsp_valid_i = 1'b1; rsp_id_i = 2'd2; rsp_data_i = 8'hEE;
        step();
        rsp_valid_i = 1'b0;
        check("err_pulse", 32'(err_o), 32'd1);
        check("err_no_valid", 32'(out_valid_o), 32'd0);
        check("err_empty", 32'(empty_o), 32'd1);
        step();
        check("err_cleared", 32'(err_o), 32'd0);

        // Backpressure: head held stable for five cycles, then accepted.
        out_ready_i = 1'b0;
        req_valid_i = 1'b1;
        #1;
        check("bp_alloc_id", 32'(req_id_o), 32'd0);
        step();
        req_valid_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_id_i = 2'd0; rsp_data_i = 8'h5A;
        step();
        rsp_valid_i = 1'b0; rsp_data_i = 8'h00;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_data", 32'(out_data_o), 32'h5A);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        check("bp_accept_valid", 32'(out_valid_o), 32'd1);
        step();
        check("bp_empty", 32'(empty_o), 32'd1);
        check("bp_out_id", 32'(out_id_o), 32'd1);

        // Pipelined throughput: alloc, respond and release every cycle; pointers start at 5.
        for (int c = 0; c < 12; c++) begin
            req_valid_i = (c < 10);
            rsp_valid_i = (c >= 1) && (c <= 10);
            rsp_id_i    = 2'((5 + c - 1) % 4);
            rsp_data_i  = 8'(8'h30 + c - 1);
            #1;
            if (c < 10) begin
                check("tp_req_id", 32'(req_id_o), 32'((5 + c) % 4));
                check("tp_req_ready", 32'(req_ready_o), 32'd1);
            end
            if (c >= 2) begin
                check("tp_valid", 32'(out_valid_o), 32'd1);
                check("tp_data", 32'(out_data_o), 32'(8'h30 + c - 2));
                check("tp_out_id", 32'(out_id_o), 32'((5 + c - 2) % 4));
            end
            step();
        end
        req_valid_i = 1'b0; rsp_valid_i = 1'b0;
        check("tp_empty", 32'(empty_o), 32'd1);
        check("tp_no_err", 32'(err_o), 32'd0);

        // Mid-traffic asynchronous reset with three tags outstanding (3,0,1).
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            #1;
            check("mr_alloc_id", 32'(req_id_o), 32'((15 + i) % 4));
            step();
        end
        req_valid_i = 1'b0; out_ready_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_id_i = 2'd3; rsp_data_i = 8'h77;
        step();
        rsp_valid_i = 1'b0;
        check("mr_head_valid", 32'(out_valid_o), 32'd1);
        check("mr_head_data", 32'(out_data_o), 32'h77);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mr");
        #1;
        rst_ni = 1'b1;
        step();
        rsp_valid_i = 1'b1; rsp_id_i = 2'd1; rsp_data_i = 8'h11;
        step();
        rsp_valid_i = 1'b0;
        check("late_rsp_err", 32'(err_o), 32'd1);
        check("late_rsp_valid", 32'(out_valid_o), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rob_reorder

// File: doc/rob_reorder.md
Name: rob_reorder

Overview:
- Response-side reorder buffer: the complement of the in-order request FIFO.
- Allocates an ordered tag per outbound request.
- Accepts out-of-order responses tagged with that ID.
- Releases response data strictly in allocation order over a valid/ready output.

Parameters:
- DATA_WIDTH, 8, width of response payload.
- DEPTH, 4, number of outstanding tags; power of 2, >= 2.
- ID_WIDTH, $clog2(DEPTH), tag width (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  requester asks for a tag.
- req_ready_o  output  1  tag available (= ~full_o).
- req_id_o  output  ID_WIDTH  tag granted on req_valid_i && req_ready_o.
- rsp_valid_i  input  1  response beat present.
- rsp_id_i  input  ID_WIDTH  tag of response.
- rsp_data_i  input  DATA_WIDTH  response payload.
- out_valid_o  output  1  head response available.
- out_ready_i  input  1  consumer accepts head.
- out_id_o  output  ID_WIDTH  tag of head entry.
- out_data_o  output  DATA_WIDTH  head payload.
- full_o  output  1  all DEPTH tags outstanding.
- empty_o  output  1  no tags outstanding.
- err_o  output  1  one-cycle pulse: response to a slot not PENDING.

Behaviour:
- Pointers:
  - alloc_ptr and rel_ptr, ID_WIDTH+1 bits each (extra wrap bit).
  - empty_o = pointers equal.
  - full_o = MSBs differ and low bits equal.
  - Both pointers wrap naturally modulo 2*DEPTH.
- Per-slot state FREE -> PENDING -> READY -> FREE:
  - Alloc (req_valid_i && ~full_o): slot[alloc_ptr] FREE -> PENDING; alloc_ptr+1. req_id_o = alloc_ptr[ID_WIDTH-1:0], combinational.
  - Response (rsp_valid_i), slot[rsp_id_i] PENDING: data captured, slot -> READY.
  - Response, slot[rsp_id_i] FREE or READY: response dropped, state and data unchanged, err_o = 1 next cycle.
  - Release (out_valid_o && out_ready_i): slot[rel_ptr] -> FREE; rel_ptr+1.
- Outputs:
  - out_valid_o = slot[rel_ptr] == READY; out_data_o and out_id_o are driven from registered storage.
  - Response-to-output latency is 1 cycle minimum.
  - out_valid_o stays asserted and out_data_o stays stable until accepted.
- Responses are always accepted; there is no rsp_ready.
- Simultaneous events:
  - Alloc + release in the same cycle: both take effect.
  - full_o and req_ready_o use registered pointers, so no alloc occurs while full even if a release happens that cycle.
  - Response to slot X + release of a different head slot: both take effect.
  - A response to the head slot while that slot is PENDING cannot coincide with its release; release applies only to READY.
- Reset (asynchronous, any time):
  - All slots FREE, storage 0, pointers 0.
  - empty_o=1, full_o=0, req_ready_o=1, out_valid_o=0, err_o=0, req_id_o=0, out_id_o=0, out_data_o=0.
  - In-flight tags are forgotten; responses arriving after reset raise err_o.

Optional Feature:
- ROB_BYPASS_EN defined:
  - A response whose rsp_id_i equals the head slot, while that slot is PENDING, drives out_valid_o=1 and out_data_o=rsp_data_i combinationally in the same cycle.
  - If out_ready_i=1, the slot goes PENDING -> FREE directly and rel_ptr advances; otherwise the slot goes to READY as normal.
  - Zero-cycle latency for in-order traffic.
- ROB_BYPASS_EN undefined:
  - No rsp -> out combinational path; minimum latency 1 cycle.

Decomposition:
- Package rob_pkg:
  - slot_state_e enum (FREE=2'b00, PENDING=2'b01, READY=2'b10).
  - Default width constants.
- Sub-module rob_ptr: wrap-bit pointer register with increment enable, asynchronous reset; instantiated twice (alloc, release).
- Slot state array and storage stay in the top module.

Test Plan:
- Reset then 4 allocs, DEPTH=4 -> req_id_o = 0,1,2,3; full_o=1 after 4th; 5th req_valid_i sees req_ready_o=0.
- Tags 0..3 outstanding; responses id 3,1,2,0 with data 0xD3,0xD1,0xD2,0xD0; out_ready_i=1 -> nothing out until id 0 arrives, then 0xD0,0xD1,0xD2,0xD3 on consecutive cycles, empty_o=1 after.
- Response id 2 when slot 2 FREE -> err_o pulses 1 cycle, out_valid_o stays 0, state unchanged.
- Head READY, out_ready_i=0 for 5 cycles -> out_valid_o held, out_data_o stable; then accept, rel_ptr advances.
- 10 alloc/response/release rounds at full throughput -> pointers wrap past 2*DEPTH, IDs cycle 0..3, order preserved.
- Assert rst_ni mid-traffic with 3 tags outstanding -> all outputs at reset values immediately; a late response id 1 raises err_o.
